// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel switch debouncer.
// Lane state encodings and a constant-evaluable ceil(log2) helper.
package debounce_pkg;

    localparam logic [1:0] ST_ZERO  = 2'b00;
    localparam logic [1:0] ST_WAIT0 = 2'b01;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_WAIT1 = 2'b11;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input longint unsigned value);
        int result;
        longint unsigned remaining;
        result = 0;
        if (value > 1) begin
            remaining = value - 1;
            while (remaining > 0) begin
                result = result + 1;
                remaining = remaining >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Switch-input / debounced-output bundle between board pins and UI logic.
// The master side drives the raw switches; the slave side is the debouncer.
interface debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] sw;
    logic [CHANNELS-1:0] db_level;
    logic [CHANNELS-1:0] rise_tick;
    logic [CHANNELS-1:0] fall_tick;
    logic [CHANNELS-1:0] hold_tick;

    modport master (
        output sw,
        input  db_level,
        input  rise_tick,
        input  fall_tick,
        input  hold_tick
    );

    modport slave (
        input  sw,
        output db_level,
        output rise_tick,
        output fall_tick,
        output hold_tick
    );
endinterface

// File: rtl/debounce_lane.sv
// One debouncer lane: synchroniser, four-state debounce FSM with interval
// counter, and a saturating long-press counter.
module debounce_lane
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES   = 2000000,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic rise_tick,
    output logic fall_tick,
    output logic hold_tick
);

    localparam int CW = clog2(longint'(DB_CYCLES) + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [1:0]             state;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A sample matching the current level during WAITx aborts the change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ZERO;
            cnt       <= '0;
            db_level  <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            case (state)
                ST_ZERO: begin
                    if (s) begin
                        state <= ST_WAIT1;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_WAIT1: begin
                    if (!s) begin
                        state <= ST_ZERO;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state     <= ST_ONE;
                        db_level  <= 1'b1;
                        rise_tick <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (!s) begin
                        state <= ST_WAIT0;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_WAIT0: begin
                    if (s) begin
                        state <= ST_ONE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state     <= ST_ZERO;
                        db_level  <= 1'b0;
                        fall_tick <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_ZERO;
                    db_level <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (HOLD_CYCLES == 0) begin : g_no_hold
            assign hold_tick = 1'b0;
        end else begin : g_hold
            localparam int HW = clog2(longint'(HOLD_CYCLES) + 1);
            logic [HW-1:0] hold_cnt;

            // Only a fresh press clears the count, so bounces in WAIT0 cannot re-arm it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hold_cnt  <= '0;
                    hold_tick <= 1'b0;
                end else begin
                    hold_tick <= 1'b0;
                    if (state == ST_WAIT1 && s && cnt == '0) begin
                        hold_cnt <= '0;
                    end else if ((state == ST_ONE || state == ST_WAIT0) &&
                                 hold_cnt != HW'(HOLD_CYCLES)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                            hold_tick <= 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: CHANNELS independent lanes sharing clk/reset,
// each with its own level, rise/fall ticks and long-press tick.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DB_CYCLES   = 2000000,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    debounce_multi_if.slave bus
);

    logic [CHANNELS-1:0] db_level;
    logic [CHANNELS-1:0] rise_tick;
    logic [CHANNELS-1:0] fall_tick;
    logic [CHANNELS-1:0] hold_tick;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        debounce_lane #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .sw        (bus.sw[i]),
            .db_level  (db_level[i]),
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i]),
            .hold_tick (hold_tick[i])
        );
    end

    assign bus.db_level  = db_level;
    assign bus.rise_tick = rise_tick;
    assign bus.fall_tick = fall_tick;
    assign bus.hold_tick = hold_tick;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with a run-length behavioural model
// checked every cycle plus hand-computed edge-exact expectations.
module tb_debounce_multi;

    localparam int CHANNELS    = 4;
    localparam int DB_CYCLES   = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYCLES = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    debounce_multi_if #(.CHANNELS(CHANNELS)) bus ();

    debounce_multi #(
        .CHANNELS    (CHANNELS),
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: a lane flips once the synchronised input has disagreed with the
    // debounced level for DB_CYCLES+1 consecutive edges; hold fires HOLD_CYCLES
    // high edges after a rise.
    logic [CHANNELS-1:0] hist [SYNC_STAGES];
    logic [CHANNELS-1:0] m_level = '0;
    logic [CHANNELS-1:0] m_rise = '0;
    logic [CHANNELS-1:0] m_fall = '0;
    logic [CHANNELS-1:0] m_hold = '0;
    int                  run [CHANNELS];
    int                  since [CHANNELS];

    initial begin
        logic [CHANNELS-1:0] seen;
        logic                prev;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int k = 0; k < SYNC_STAGES; k++) hist[k] = '0;
                m_level = '0;
                m_rise  = '0;
                m_fall  = '0;
                m_hold  = '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    run[i]   = 0;
                    since[i] = 0;
                end
            end else begin
                seen   = hist[SYNC_STAGES-1];
                m_rise = '0;
                m_fall = '0;
                m_hold = '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    prev = m_level[i];
                    if (prev) begin
                        since[i] = since[i] + 1;
                        if (since[i] == HOLD_CYCLES) m_hold[i] = 1'b1;
                    end
                    if (seen[i] != prev) begin
                        run[i] = run[i] + 1;
                        if (run[i] == DB_CYCLES + 1) begin
                            m_level[i] = seen[i];
                            run[i] = 0;
                            if (seen[i]) begin
                                m_rise[i] = 1'b1;
                                since[i]  = 0;
                            end else begin
                                m_fall[i] = 1'b1;
                            end
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
                for (int k = SYNC_STAGES - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = bus.sw;
            end
        end
    end

    task automatic check_output(input string name, input logic [CHANNELS-1:0] actual,
                                input logic [CHANNELS-1:0] expected);
        compared = compared + 1;
        if (actual !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %b, expected %b at time %0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_output("model_db_level",  bus.db_level,  m_level);
            check_output("model_rise_tick", bus.rise_tick, m_rise);
            check_output("model_fall_tick", bus.fall_tick, m_fall);
            check_output("model_hold_tick", bus.hold_tick, m_hold);
        end
    end

    task automatic apply_stimulus(input logic [CHANNELS-1:0] value);
        @(negedge clk);
        bus.sw = value;
    endtask

    // Advance n active edges and sample just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.sw = '0;
        reset  = 1'b1;
        step(3);
        check_output("reset_db_level",  bus.db_level,  4'b0000);
        check_output("reset_rise_tick", bus.rise_tick, 4'b0000);
        check_output("reset_hold_tick", bus.hold_tick, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        step(4);

        $display("[TB] clean press on lane 0");
        apply_stimulus(4'b0001);
        step(10);
        check_output("clean_rise_edge10", bus.rise_tick, 4'b0000);
        step(1);
        check_output("clean_rise_edge11", bus.rise_tick, 4'b0001);
        check_output("clean_level_edge11", bus.db_level, 4'b0001);
        step(1);
        check_output("clean_rise_edge12", bus.rise_tick, 4'b0000);
        step(18);
        check_output("clean_hold_edge30", bus.hold_tick, 4'b0000);
        step(1);
        check_output("clean_hold_edge31", bus.hold_tick, 4'b0001);
        step(1);
        check_output("clean_hold_edge32", bus.hold_tick, 4'b0000);
        step(9);
        apply_stimulus(4'b0000);
        step(20);
        check_output("clean_released", bus.db_level, 4'b0000);

        $display("[TB] short release on lane 0");
        apply_stimulus(4'b0001);
        step(15);
        apply_stimulus(4'b0000);
        step(10);
        check_output("short_level_edge10", bus.db_level, 4'b0001);
        check_output("short_fall_edge10", bus.fall_tick, 4'b0000);
        step(1);
        check_output("short_fall_edge11", bus.fall_tick, 4'b0001);
        check_output("short_level_edge11", bus.db_level, 4'b0000);
        step(25);

        $display("[TB] bouncy press on lane 1");
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(4'b0010);
            step(5);
            apply_stimulus(4'b0000);
            step(3);
        end
        check_output("bouncy_level_during", bus.db_level, 4'b0000);
        apply_stimulus(4'b0010);
        step(10);
        check_output("bouncy_rise_edge10", bus.rise_tick, 4'b0000);
        step(1);
        check_output("bouncy_rise_edge11", bus.rise_tick, 4'b0010);
        check_output("bouncy_level_edge11", bus.db_level, 4'b0010);
        step(2);
        apply_stimulus(4'b0000);
        step(20);

        $display("[TB] glitch while high on lane 2");
        apply_stimulus(4'b0100);
        step(11);
        check_output("glitch_level_risen", bus.db_level, 4'b0100);
        step(4);
        apply_stimulus(4'b0000);
        step(3);
        apply_stimulus(4'b0100);
        step(12);
        check_output("glitch_level_kept", bus.db_level, 4'b0100);
        check_output("glitch_hold_edge30", bus.hold_tick, 4'b0000);
        step(1);
        check_output("glitch_hold_edge31", bus.hold_tick, 4'b0100);
        apply_stimulus(4'b0000);
        step(20);

        $display("[TB] simultaneous press on lanes 1 and 3");
        apply_stimulus(4'b1010);
        step(10);
        check_output("simul_rise_edge10", bus.rise_tick, 4'b0000);
        step(1);
        check_output("simul_rise_edge11", bus.rise_tick, 4'b1010);
        check_output("simul_level_edge11", bus.db_level, 4'b1010);
        apply_stimulus(4'b0000);
        step(20);

        $display("[TB] reset during a press");
        apply_stimulus(4'b1000);
        step(12);
        check_output("prereset_level", bus.db_level, 4'b1000);
        apply_stimulus(4'b1001);
        step(5);
        reset = 1'b1;
        #1;
        check_output("reset_async_level", bus.db_level, 4'b0000);
        check_output("reset_async_ticks", bus.rise_tick | bus.fall_tick | bus.hold_tick, 4'b0000);
        step(2);
        @(negedge clk);
        reset = 1'b0;
        step(10);
        check_output("postreset_rise_edge10", bus.rise_tick, 4'b0000);
        step(1);
        check_output("postreset_rise_edge11", bus.rise_tick, 4'b1001);
        check_output("postreset_level_edge11", bus.db_level, 4'b1001);
        apply_stimulus(4'b0000);
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
